// File: rtl/bsg_wormhole_packet_collector.sv
// bsg_wormhole_packet_collector: reassembles a wormhole header+body flit stream into one wide packet word, draining oversize packets
module bsg_wormhole_packet_collector #(
  parameter int width_p = 32,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int len_width_p = 4,
  parameter int max_len_p = 3,
  parameter bit header_on_lsb_p = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             v_i,
  input  logic [width_p-1:0]               data_i,
  output logic                             ready_o,
  output logic                             v_o,
  output logic [(max_len_p+1)*width_p-1:0] data_o,
  output logic [len_width_p-1:0]           len_o,
  input  logic                             ready_i,
  output logic                             err_o
);
  localparam int len_lsb_lp = header_on_lsb_p ? x_cord_width_p + y_cord_width_p
                                              : width_p - x_cord_width_p - y_cord_width_p - len_width_p;
  localparam int pkt_w_lp = (max_len_p + 1) * width_p;
  localparam logic [len_width_p-1:0] one_lp = len_width_p'(1);
  localparam logic [len_width_p-1:0] max_lp = len_width_p'(max_len_p);
  typedef enum logic [1:0] {IDLE, COLLECT, SEND, DRAIN} state_e;
  state_e state_r, state_n;
  logic [len_width_p-1:0] count_r, hdr_len, slot;
  logic fire, last;
  assign ready_o = state_r != SEND;
  assign v_o = state_r == SEND;
  assign fire = v_i & ready_o;
  assign last = fire & (count_r == one_lp);
  assign hdr_len = data_i[len_lsb_lp +: len_width_p];
  assign slot = len_o - count_r + one_lp;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_r <= IDLE;
    else state_r <= state_n;
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (fire) state_n = hdr_len == '0 ? SEND : hdr_len > max_lp ? DRAIN : COLLECT;
      COLLECT: if (last) state_n = SEND;
      SEND:    if (ready_i) state_n = IDLE;
      DRAIN:   if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      count_r <= '0;
      data_o  <= '0;
      len_o   <= '0;
      err_o   <= 1'b0;
    end else begin
      err_o <= state_r == DRAIN && last;
      if (fire && state_r == IDLE) begin
        data_o  <= pkt_w_lp'(data_i);
        len_o   <= hdr_len;
        count_r <= hdr_len;
      end else if (fire) begin
        if (state_r == COLLECT) data_o[slot*width_p +: width_p] <= data_i;
        count_r <= count_r - one_lp;
      end
    end
  always_ff @(posedge clk_i)
    assert (max_len_p >= 1 && max_len_p < 2 ** len_width_p);
endmodule

// File: tb/tb_bsg_wormhole_packet_collector.sv
// tb_bsg_wormhole_packet_collector: packet-level model plus directed checks for LSB and MSB header layouts
module tb_bsg_wormhole_packet_collector;
  logic clk = 1'b0, rst_n = 1'b0;
  logic va = 1'b0, vb = 1'b0, ra = 1'b1, rb = 1'b1;
  logic [31:0] da = '0, db = '0;
  logic rdya, rdyb, voa, vob, erra, errb;
  logic [127:0] doa, dob;
  logic [3:0] lena, lenb;
  int checks = 0, errors = 0;
  int got [2];
  int need [2];
  logic [127:0] mbuf [2];
  logic [3:0] mlen [2];
  bit pend [2];
  bit merr [2];
  always #5 clk = ~clk;
  bsg_wormhole_packet_collector #(.header_on_lsb_p(1'b1)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(va), .data_i(da), .ready_o(rdya),
    .v_o(voa), .data_o(doa), .len_o(lena), .ready_i(ra), .err_o(erra));
  bsg_wormhole_packet_collector #(.header_on_lsb_p(1'b0)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(vb), .data_i(db), .ready_o(rdyb),
    .v_o(vob), .data_o(dob), .len_o(lenb), .ready_i(rb), .err_o(errb));
  task automatic chk(string n, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step(int i, logic v, logic [31:0] d, logic r);
    logic [3:0] l;
    l = i == 0 ? d[11:8] : d[23:20];
    merr[i] = 1'b0;
    if (pend[i]) begin
      if (r) pend[i] = 1'b0;
    end else if (v) begin
      if (got[i] == 0) begin
        need[i] = int'(l);
        mlen[i] = l;
        mbuf[i] = {96'b0, d};
      end else if (need[i] <= 3) mbuf[i][got[i]*32 +: 32] = d;
      got[i]++;
      if (got[i] == need[i] + 1) begin
        got[i] = 0;
        if (need[i] > 3) merr[i] = 1'b1;
        else pend[i] = 1'b1;
      end
    end
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        got[i] = 0;
        need[i] = 0;
        mbuf[i] = '0;
        mlen[i] = '0;
        pend[i] = 1'b0;
        merr[i] = 1'b0;
      end
    end else begin
      step(0, va, da, ra);
      step(1, vb, db, rb);
    end
  always @(negedge clk) begin
    chk("a_v_o", 128'(voa), 128'(pend[0]));
    chk("a_ready_o", 128'(rdya), 128'(!pend[0]));
    chk("a_err_o", 128'(erra), 128'(merr[0]));
    chk("b_v_o", 128'(vob), 128'(pend[1]));
    chk("b_ready_o", 128'(rdyb), 128'(!pend[1]));
    chk("b_err_o", 128'(errb), 128'(merr[1]));
    if (pend[0]) begin
      chk("a_data_o", doa, mbuf[0]);
      chk("a_len_o", 128'(lena), 128'(mlen[0]));
    end
    if (pend[1]) begin
      chk("b_data_o", dob, mbuf[1]);
      chk("b_len_o", 128'(lenb), 128'(mlen[1]));
    end
  end
  task automatic cyc(int i, logic v, logic [31:0] d, logic r);
    if (i == 0) begin
      va = v; da = d; ra = r; vb = 1'b0; rb = 1'b1;
    end else begin
      vb = v; db = d; rb = r; va = 1'b0; ra = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_v_o", 128'(voa), 128'd0);
    chk("rst_err_o", 128'(erra), 128'd0);
    chk("rst_data_o", doa, 128'd0);
    chk("rst_len_o", 128'(lena), 128'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready_o", 128'(rdya), 128'd1);
    cyc(0, 1'b1, 32'h0000_0015, 1'b1);
    chk("single_v_o", 128'(voa), 128'd1);
    chk("single_ready_o", 128'(rdya), 128'd0);
    chk("single_data_o", doa, 128'h15);
    chk("single_len_o", 128'(lena), 128'd0);
    cyc(0, 1'b0, 32'h0, 1'b1);
    chk("single_done", 128'(voa), 128'd0);
    cyc(0, 1'b1, 32'h0000_0300, 1'b1);
    cyc(0, 1'b1, 32'h0000_000a, 1'b1);
    cyc(0, 1'b1, 32'h0000_000b, 1'b1);
    cyc(0, 1'b0, 32'h0, 1'b1);
    chk("full_gap_v_o", 128'(voa), 128'd0);
    cyc(0, 1'b1, 32'h0000_000c, 1'b1);
    chk("full_v_o", 128'(voa), 128'd1);
    chk("full_data_o", doa, 128'h0000000c_0000000b_0000000a_00000300);
    chk("full_len_o", 128'(lena), 128'd3);
    cyc(0, 1'b0, 32'h0, 1'b1);
    cyc(0, 1'b1, 32'h0000_0100, 1'b0);
    cyc(0, 1'b1, 32'h0000_0055, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1'b0, 32'h0, 1'b0);
      chk("bp_v_o", 128'(voa), 128'd1);
      chk("bp_ready_o", 128'(rdya), 128'd0);
      chk("bp_data_o", doa, 128'h00000000_00000000_00000055_00000100);
    end
    cyc(0, 1'b0, 32'h0, 1'b1);
    chk("bp_done_v_o", 128'(voa), 128'd0);
    chk("bp_done_ready_o", 128'(rdya), 128'd1);
    cyc(0, 1'b1, 32'h0000_0500, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      chk("drain_ready_o", 128'(rdya), 128'd1);
      chk("drain_err_early", 128'(erra), 128'd0);
      cyc(0, 1'b1, 32'(k), 1'b1);
    end
    chk("drain_err_o", 128'(erra), 128'd1);
    chk("drain_v_o", 128'(voa), 128'd0);
    cyc(0, 1'b0, 32'h0, 1'b1);
    chk("drain_err_pulse", 128'(erra), 128'd0);
    cyc(0, 1'b1, 32'h0000_0100, 1'b1);
    cyc(0, 1'b1, 32'h0000_0077, 1'b1);
    chk("post_drain_v_o", 128'(voa), 128'd1);
    chk("post_drain_data_o", doa, 128'h00000000_00000000_00000077_00000100);
    cyc(0, 1'b0, 32'h0, 1'b1);
    cyc(0, 1'b1, 32'h0000_0200, 1'b1);
    cyc(0, 1'b1, 32'h0000_0099, 1'b1);
    va = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_v_o", 128'(voa), 128'd0);
    chk("midrst_ready_o", 128'(rdya), 128'd1);
    #9 rst_n = 1'b1;
    #1;
    chk("postrst_v_o", 128'(voa), 128'd0);
    chk("postrst_ready_o", 128'(rdya), 128'd1);
    @(posedge clk);
    #1;
    cyc(0, 1'b1, 32'h0000_0035, 1'b1);
    chk("postrst_data_o", doa, 128'h35);
    chk("postrst_len_o", 128'(lena), 128'd0);
    chk("postrst_pkt_v_o", 128'(voa), 128'd1);
    cyc(0, 1'b0, 32'h0, 1'b1);
    cyc(1, 1'b1, 32'h3520_0000, 1'b1);
    chk("msb_hdr_v_o", 128'(vob), 128'd0);
    cyc(1, 1'b1, 32'h0000_1111, 1'b1);
    chk("msb_mid_v_o", 128'(vob), 128'd0);
    cyc(1, 1'b1, 32'h0000_2222, 1'b1);
    chk("msb_v_o", 128'(vob), 128'd1);
    chk("msb_len_o", 128'(lenb), 128'd2);
    chk("msb_data_o", dob, 128'h00000000_00002222_00001111_35200000);
    cyc(1, 1'b0, 32'h0, 1'b1);
    chk("msb_done", 128'(vob), 128'd0);
    cyc(0, 1'b0, 32'h0, 1'b1);
    cyc(0, 1'b0, 32'h0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
